// File: rtl/updown_counter_pkg.sv
// Shared types for the parametrised up/down counter: step classification and flag bundle.
package updown_counter_pkg;

  typedef enum logic [2:0] {
    HOLD,
    LOAD,
    INC,
    DEC,
    WRAP_UP,
    WRAP_DN,
    SAT_UP,
    SAT_DN
  } step_e;

  typedef struct packed {
    logic wrap;
    logic ovf;
    logic unf;
  } flags_t;

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count and step-kind decode for updown_counter_param.
// Saturation is only honoured when UPDOWN_COUNTER_PARAM_SAT_EN is defined.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MAX_VAL = 7
) (
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic             direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count_d,
  output step_e            kind
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] ld_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;
  logic           sat;
  logic [1:0]     unused_msb;

  assign cnt_ext    = {1'b0, count};
  assign ld_ext     = {1'b0, load_value};
  assign inc_ext    = cnt_ext + (WIDTH+1)'(1);
  assign dec_ext    = cnt_ext - (WIDTH+1)'(1);
  // Steps are only taken strictly inside the range, so the extension bit is always zero.
  assign unused_msb = {inc_ext[WIDTH], dec_ext[WIDTH]};

`ifdef UPDOWN_COUNTER_PARAM_SAT_EN
  assign sat = sat_mode;
`else
  logic unused_sat;
  assign unused_sat = sat_mode;
  assign sat        = 1'b0;
`endif

  always_comb begin
    kind    = HOLD;
    count_d = count;
    if (load) begin
      kind    = LOAD;
      count_d = (ld_ext > MAX_EXT) ? MAX_W : load_value;
    end else if (enable) begin
      if (direction) begin
        if (cnt_ext < MAX_EXT) begin
          kind    = INC;
          count_d = inc_ext[WIDTH-1:0];
        end else if (sat) begin
          kind = SAT_UP;
        end else begin
          kind    = WRAP_UP;
          count_d = '0;
        end
      end else begin
        if (count != '0) begin
          kind    = DEC;
          count_d = dec_ext[WIDTH-1:0];
        end else if (sat) begin
          kind = SAT_DN;
        end else begin
          kind    = WRAP_DN;
          count_d = MAX_W;
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate, wrap pulse and sticky flags.
// Saturation support is enabled by defining UPDOWN_COUNTER_PARAM_SAT_EN.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_VAL   = 7,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             sat_mode,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_pulse,
  output logic             overflow_sticky,
  output logic             underflow_sticky
);

  if (WIDTH < 1 || MAX_VAL > (2**WIDTH - 1) || RESET_VAL > MAX_VAL) begin : g_bad_params
    $error("updown_counter_param: illegal WIDTH/MAX_VAL/RESET_VAL combination");
  end

  logic [WIDTH-1:0] count_q, count_d;
  flags_t           flags_q, flags_d;
  step_e            kind;

  updown_counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count      (count_q),
    .enable     (enable),
    .direction  (direction),
    .load       (load),
    .load_value (load_value),
    .sat_mode   (sat_mode),
    .count_d    (count_d),
    .kind       (kind)
  );

  // A set event in the same cycle as clear_flags wins over the clear.
  always_comb begin
    flags_d      = flags_q;
    flags_d.wrap = (kind == WRAP_UP) || (kind == WRAP_DN);
    flags_d.ovf  = (kind == WRAP_UP) || (kind == SAT_UP) || (flags_q.ovf && !clear_flags);
    flags_d.unf  = (kind == WRAP_DN) || (kind == SAT_DN) || (flags_q.unf && !clear_flags);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= WIDTH'(RESET_VAL);
      flags_q <= '0;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign count            = count_q;
  assign at_max           = (count_q == WIDTH'(MAX_VAL));
  assign at_min           = (count_q == '0);
  assign wrap_pulse       = flags_q.wrap;
  assign overflow_sticky  = flags_q.ovf;
  assign underflow_sticky = flags_q.unf;

endmodule
